mont_iter_ctrl: RTL and testbench

Bit-serial radix-2 Montgomery multiplication controller that sits directly upstream of the registered carry-select adder stage (`mpadderB`). It drives that adder's operand inputs and consumes its result and 16-bit low-order prediction, issuing two additions per multiplier bit. For each operation it returns C = A·B·2^-N mod M, without final subtraction, so C < 2M. The adder is instantiated at the next level up; this block only owns the iteration state, operand latches and accumulator.

---
 rtl/mont_iter_ctrl_if.sv | 28 ++
 rtl/mont_iter_ctrl.sv | 97 +++++++++
 tb/tb_mont_iter_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mont_iter_ctrl_if.sv
// Operand/result bundle and adder-operand bus of the bit-serial Montgomery controller.
// slave is the controller's view; master is the requester plus the downstream adder.
interface mont_iter_ctrl_if #(
    parameter int N    = 1024,
    parameter int ADDW = 1028
);
    logic            start;
    logic [N-1:0]    in_a;
    logic [N-1:0]    in_b;
    logic [N-1:0]    in_m;
    logic            busy;
    logic            done;
    logic [N:0]      result;
    logic [ADDW-1:0] add_a;
    logic [ADDW-1:0] add_b;
    logic [ADDW:0]   add_result;
    logic [15:0]     add_prediction;

    modport slave (
        input  start, in_a, in_b, in_m, add_result, add_prediction,
        output busy, done, result, add_a, add_b
    );

    modport master (
        output start, in_a, in_b, in_m, add_result, add_prediction,
        input  busy, done, result, add_a, add_b
    );
endinterface

// File: rtl/mont_iter_ctrl.sv
// Radix-2 Montgomery iteration controller: C = A*B*2^-N mod M (C < 2M), two
// registered additions per multiplier bit through an external adder.
module mont_iter_ctrl #(
    parameter int N    = 1024,
    parameter int ADDW = 1028
) (
    input  logic            clk,
    input  logic            rst,
    mont_iter_ctrl_if.slave bus
);
    localparam int IX = $clog2(N);
    localparam int IW = IX + 1;

    typedef enum logic [2:0] {IDLE, ADD_B, WAIT_B, ADD_M, WAIT_M, DONE} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d, m_q, m_d;
    // C + a_i*B can reach 3M, so the accumulator keeps one bit above the result width.
    logic [N+1:0]    c_q, c_d;
    logic            q_q, q_d;
    logic [IW-1:0]   i_q, i_d;
    logic [ADDW-1:0] add_b_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            c_q     <= '0;
            q_q     <= 1'b0;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            c_q     <= c_d;
            q_q     <= q_d;
            i_q     <= i_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        c_d     = c_q;
        q_d     = q_q;
        i_d     = i_q;
        add_b_w = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    m_d     = bus.in_m;
                    c_d     = '0;
                    i_d     = '0;
                    state_d = ADD_B;
                end
            end
            ADD_B: begin
                if (a_q[i_q[IX-1:0]]) add_b_w = ADDW'(b_q);
                // Low adder block has no carry-in, so bit 0 of the sum is exact this cycle.
                q_d     = bus.add_prediction[0];
                state_d = WAIT_B;
            end
            WAIT_B: begin
                c_d     = bus.add_result[N+1:0];
                state_d = ADD_M;
            end
            ADD_M: begin
                if (q_q) add_b_w = ADDW'(m_q);
                state_d = WAIT_M;
            end
            WAIT_M: begin
                c_d     = {1'b0, bus.add_result[N+1:1]};
                i_d     = i_q + 1'b1;
                state_d = (i_q == IW'(N - 1)) ? DONE : ADD_B;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = c_q[N:0];
    assign bus.add_a  = ADDW'(c_q);
    assign bus.add_b  = add_b_w;

    // Sums stay below 4M < 2^(N+2); the upper adder bits carry nothing.
    logic unused_bits;
    assign unused_bits = ^{bus.add_result[ADDW:N+2], bus.add_prediction[15:1]};
endmodule

// File: tb/tb_mont_iter_ctrl.sv
// Bench for mont_iter_ctrl: an N=8 and an N=1024 instance, each fed by a behavioural
// adder, checked every cycle against a Montgomery trace model plus literal pins.
module tb_mont_iter_ctrl;
    localparam int NS = 8;
    localparam int AS = 10;
    localparam int NL = 1024;
    localparam int AL = 1028;
    localparam int WW = 1032;
    typedef logic [WW-1:0] wide_t;
    typedef logic [2111:0] big_t;

    logic clk = 1'b0;
    logic rst8, rst1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mont_iter_ctrl_if #(.N(NS), .ADDW(AS)) if8 ();
    mont_iter_ctrl_if #(.N(NL), .ADDW(AL)) if1 ();

    mont_iter_ctrl #(.N(NS), .ADDW(AS)) u8 (.clk(clk), .rst(rst8), .bus(if8));
    mont_iter_ctrl #(.N(NL), .ADDW(AL)) u1 (.clk(clk), .rst(rst1), .bus(if1));

    // Behavioural registered adder: sum visible next cycle, low 16 bits immediately.
    logic [AS:0] sum8;
    logic [AL:0] sum1;
    assign sum8 = {1'b0, if8.add_a} + {1'b0, if8.add_b};
    assign sum1 = {1'b0, if1.add_a} + {1'b0, if1.add_b};
    assign if8.add_prediction = 16'(sum8);
    assign if1.add_prediction = sum1[15:0];
    always @(posedge clk) begin
        if8.add_result <= sum8;
        if1.add_result <= sum1;
    end

    task automatic chk(input string name, input wide_t act, input wide_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h (low 128 bits)", name, cyc, act[127:0], exp[127:0]);
        end
    endtask

    function automatic int nbits(input int d);
        return (d == 0) ? NS : NL;
    endfunction

    function automatic bit congr_ok(input wide_t r, input wide_t a, input wide_t b, input wide_t m, input int n);
        big_t l, p, mb;
        mb = big_t'(m);
        l  = big_t'(r) << n;
        p  = big_t'(a) * big_t'(b);
        return (l % mb) == (p % mb);
    endfunction

    // Model: per run, the accumulator before each bit (tr_c) and the sum C + a_i*B (tr_s).
    bit    en [2];
    bit    act [2];
    int    s0 [2];
    wide_t ma [2];
    wide_t mb [2];
    wide_t mm [2];
    wide_t last [2];
    wide_t tr_c [2][0:NL];
    wide_t tr_s [2][0:NL-1];

    task automatic model_step(input int d, input logic r, input logic st,
                              input wide_t ia, input wide_t ib, input wide_t im,
                              input logic busy, input logic done, input wide_t res,
                              input wide_t aa, input wide_t ab, input wide_t ar);
        int    n = nbits(d);
        int    p, i, k;
        wide_t one = 1;
        wide_t mres, e_c, e_b, c, sm;
        logic  e_busy, e_done;
        mres   = (one << (n + 1)) - one;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_c    = last[d];
        e_b    = '0;
        if (en[d]) begin
            if (act[d]) begin
                p      = cyc - s0[d];
                e_busy = 1'b1;
                if (p == 4 * n + 1) begin
                    e_done = 1'b1;
                    e_c    = tr_c[d][n];
                end else begin
                    i   = (p - 1) / 4;
                    k   = (p - 1) % 4;
                    e_c = (k < 2) ? tr_c[d][i] : tr_s[d][i];
                    if (k == 0 && ma[d][i]) e_b = mb[d];
                    if (k == 2 && tr_s[d][i][0]) e_b = mm[d];
                end
            end
            chk("busy", wide_t'(busy), wide_t'(e_busy));
            chk("done", wide_t'(done), wide_t'(e_done));
            chk("result", res, e_c & mres);
            chk("add_a", aa, e_c);
            chk("add_b", ab, e_b);
            if (e_busy) chk("add_result_hi", ar >> (n + 2), '0);
            if (e_done) begin
                chk("congruent", wide_t'(congr_ok(res, ma[d], mb[d], mm[d], n)), wide_t'(1));
                chk("below_2m", wide_t'(res < (mm[d] << 1)), wide_t'(1));
                act[d]  = 1'b0;
                last[d] = tr_c[d][n];
            end
        end
        if (r) begin
            en[d]   = 1'b1;
            act[d]  = 1'b0;
            last[d] = '0;
        end else if (en[d] && !e_busy && st) begin
            act[d]  = 1'b1;
            s0[d]   = cyc;
            ma[d]   = ia;
            mb[d]   = ib;
            mm[d]   = im;
            last[d] = '0;
            c       = '0;
            tr_c[d][0] = '0;
            for (int j = 0; j < n; j++) begin
                sm = c + (ia[j] ? ib : '0);
                tr_s[d][j] = sm;
                c  = (sm + (sm[0] ? im : '0)) >> 1;
                tr_c[d][j+1] = c;
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0, rst8, if8.start, wide_t'(if8.in_a), wide_t'(if8.in_b), wide_t'(if8.in_m),
                   if8.busy, if8.done, wide_t'(if8.result), wide_t'(if8.add_a),
                   wide_t'(if8.add_b), wide_t'(if8.add_result));
        model_step(1, rst1, if1.start, wide_t'(if1.in_a), wide_t'(if1.in_b), wide_t'(if1.in_m),
                   if1.busy, if1.done, wide_t'(if1.result), wide_t'(if1.add_a),
                   wide_t'(if1.add_b), wide_t'(if1.add_result));
    end

    task automatic go(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ops8(input int a, input int b, input int m);
        if8.in_a = 8'(a);
        if8.in_b = 8'(b);
        if8.in_m = 8'(m);
    endtask

    task automatic rnd_ops8();
        int m, b, a;
        m = ($urandom_range(3) == 0) ? 255 : int'($urandom_range(255) | 1);
        b = ($urandom_range(3) == 0) ? m - 1 : int'($urandom_range(m - 1));
        a = ($urandom_range(3) == 0) ? 255 : int'($urandom_range(255));
        ops8(a, b, m);
    endtask

    function automatic wide_t rnd_w(input int n);
        wide_t x = '0;
        wide_t one = 1;
        for (int w = 0; w < (n + 31) / 32; w++) x[w*32 +: 32] = $urandom;
        return x & ((one << n) - one);
    endfunction

    task automatic drv8();
        int s, s2;
        int lit [8] = '{123, 181, 94, 47, 143, 191, 215, 227};
        rst8 = 1'b1;
        if8.start = 1'b0;
        ops8(0, 0, 1);
        go(3);
        rst8 = 1'b0;
        go(1);
        chk("reset_busy", wide_t'(if8.busy), '0);
        chk("reset_result", wide_t'(if8.result), '0);

        // A=5 B=7 M=239, extra starts at +5/+20 ignored, back-to-back start at +34 with A=0.
        ops8(5, 7, 239);
        if8.start = 1'b1;
        s = cyc;
        for (int k = 1; k <= 35; k++) begin
            go(1);
            if8.start = (k == 5 || k == 20 || k == 34);
            if (k == 5 || k == 20) ops8(k, 3, 101);
            if (k == 34) ops8(0, 200, 239);
            if (k == 10)
                for (int j = 0; j < 8; j++) chk("trace_pin", tr_c[0][j+1], wide_t'(lit[j]));
            if (k == 33) begin
                chk("t1_done", wide_t'(if8.done), wide_t'(1));
                chk("t1_result", wide_t'(if8.result), wide_t'(227));
            end
            if (k == 34) chk("hold_result", wide_t'(if8.result), wide_t'(227));
            if (k == 35) begin
                chk("clear_result", wide_t'(if8.result), '0);
                chk("b2b_busy", wide_t'(if8.busy), wide_t'(1));
            end
        end
        go(32);
        chk("a0_done", wide_t'(if8.done), wide_t'(1));
        chk("a0_result", wide_t'(if8.result), '0);
        chk("a0_latency", wide_t'(cyc - s), wide_t'(67));

        // Reset mid-run, then restart two cycles later.
        go(1);
        ops8(200, 100, 251);
        if8.start = 1'b1;
        s2 = cyc;
        go(1);
        if8.start = 1'b0;
        go(13);
        rst8 = 1'b1;
        go(1);
        rst8 = 1'b0;
        chk("mid_rst_busy", wide_t'(if8.busy), '0);
        chk("mid_rst_result", wide_t'(if8.result), '0);
        chk("mid_rst_add_a", wide_t'(if8.add_a), '0);
        chk("mid_rst_add_b", wide_t'(if8.add_b), '0);
        go(1);
        ops8(5, 7, 239);
        if8.start = 1'b1;
        go(1);
        if8.start = 1'b0;
        go(32);
        chk("restart_cycle", wide_t'(cyc - s2), wide_t'(49));
        chk("restart_done", wide_t'(if8.done), wide_t'(1));
        chk("restart_result", wide_t'(if8.result), wide_t'(227));

        for (int k = 0; k < 3000; k++) begin
            go(1);
            rst8 = ($urandom_range(499) == 0);
            if8.start = ($urandom_range(5) == 0);
            rnd_ops8();
        end
        rst8 = 1'b0;
        if8.start = 1'b0;
        go(40);
    endtask

    task automatic drv1();
        int    s, t;
        bit    seen;
        wide_t one = 1;
        wide_t a, b, m;
        rst1 = 1'b1;
        if1.start = 1'b0;
        if1.in_a = '0;
        if1.in_b = '0;
        if1.in_m = '1;
        go(2);
        rst1 = 1'b0;
        go(1);
        for (int r = 0; r < 6; r++) begin
            if (r == 0) begin
                m = (one << NL) - one;
                b = m - one;
                a = m;
            end else begin
                m = rnd_w(NL) | one;
                b = rnd_w(NL) % m;
                a = rnd_w(NL);
            end
            if1.in_a = a[NL-1:0];
            if1.in_b = b[NL-1:0];
            if1.in_m = m[NL-1:0];
            if1.start = 1'b1;
            s = cyc;
            go(1);
            if1.start = 1'b0;
            go(6);
            if1.in_a = rnd_w(NL) >> 0;
            if1.start = 1'b1;
            go(1);
            if1.start = 1'b0;
            seen = 1'b0;
            t = -1;
            for (int k = 0; k < 4200 && !seen; k++) begin
                @(negedge clk);
                if (if1.done) begin
                    seen = 1'b1;
                    t = cyc;
                end
            end
            chk("latency_1024", wide_t'(t - s), wide_t'(4097));
            go(1);
        end
    endtask

    initial begin
        fork
            drv8();
            drv1();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end
endmodule
